// File: rtl/axi_st_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_st_pkg
// Description : Shared widths and skid-buffer sizing for the AXI-ST receive
//               control path.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_st_pkg;

    localparam int c_DWIDTH     = 64;
    localparam int c_CNT_W      = 32;
    localparam int c_SKID_DEPTH = 2;

    // Occupancy counter must hold 0..c_SKID_DEPTH inclusive
    localparam int c_SKID_CNT_W = $clog2(c_SKID_DEPTH + 1);

    localparam logic [c_SKID_CNT_W-1:0] c_SKID_FULL = c_SKID_CNT_W'(c_SKID_DEPTH);

endpackage
`default_nettype wire

// File: rtl/axi_st_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : axi_st_skid_buf
// Description : Two-entry circular skid buffer with push/pop interface.
//               Exposes current occupancy and next-cycle occupancy so the
//               parent can register a ready that never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_st_skid_buf
    import axi_st_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DWIDTH-1:0]       push_data,
    input  logic                    pop,
    output logic [DWIDTH-1:0]       pop_data,
    output logic [c_SKID_CNT_W-1:0] count,
    output logic [c_SKID_CNT_W-1:0] count_next
);

    logic [DWIDTH-1:0]       r_mem [c_SKID_DEPTH];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [c_SKID_CNT_W-1:0] r_count;
    logic [c_SKID_CNT_W-1:0] w_count_next;

    // Occupancy after this cycle; simultaneous push and pop cancel out
    always_comb begin
        w_count_next = r_count;
        if (push && !pop) begin
            w_count_next = r_count + c_SKID_CNT_W'(1);
        end else if (!push && pop) begin
            w_count_next = r_count - c_SKID_CNT_W'(1);
        end
    end

    // Payload storage; contents are meaningless once count is reset, so no reset here
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset discards everything held in the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

    assign pop_data   = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/axi_st_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_st_rd_ctrl
// Description : Receive-side AXI-ST control. Accepts beats into a two-entry
//               skid buffer behind a registered ready, writes them into the
//               receive FIFO, counts written beats and flags senders that
//               withdraw or alter a stalled beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_st_rd_ctrl
    import axi_st_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axist_valid,
    input  logic [DWIDTH-1:0] axist_data,
    output logic              axist_rdy,
    input  logic              fifo_full,
    output logic              fifo_wren,
    output logic [DWIDTH-1:0] fifo_wdata,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              proto_err
);

    logic                    r_rdy;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic                    r_stall;
    logic [DWIDTH-1:0]       r_prev_data;
    logic                    r_err;

    logic                    w_push;
    logic                    w_pop;
    logic [DWIDTH-1:0]       w_pop_data;
    logic [c_SKID_CNT_W-1:0] w_count;
    logic [c_SKID_CNT_W-1:0] w_count_next;

    // Pop depends only on registered occupancy and FIFO status, never on the link
    assign w_push = axist_valid & r_rdy;
    assign w_pop  = (w_count != '0) & ~fifo_full;

    axi_st_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (axist_data),
        .pop        (w_pop),
        .pop_data   (w_pop_data),
        .count      (w_count),
        .count_next (w_count_next)
    );

    // Ready looks one cycle ahead: drop it as soon as the buffer will be full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= (w_count_next < c_SKID_FULL);
        end
    end

    // Running count of beats handed to the FIFO, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    // A stalled beat must be held with identical data until accepted; error is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall     <= 1'b0;
            r_prev_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_stall     <= axist_valid & ~r_rdy;
            r_prev_data <= axist_data;
            if (r_stall && (!axist_valid || (axist_data != r_prev_data))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign axist_rdy  = r_rdy;
    assign fifo_wren  = w_pop;
    assign fifo_wdata = w_pop_data;
    assign beat_cnt   = r_beat_cnt;
    assign proto_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_st_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_st_rd_ctrl
// Description : Self-checking bench for axi_st_rd_ctrl. Stimulus drives the
//               link and FIFO status; a negedge monitor keeps a queue-based
//               model of the skid contents and compares every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_st_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axist_valid = 1'b0;
    logic [63:0] axist_data = '0;
    logic        fifo_full = 1'b0;
    logic        axist_rdy;
    logic        fifo_wren;
    logic [63:0] fifo_wdata;
    logic [31:0] beat_cnt;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    // Reference model state: beats sitting in the receiver, in arrival order
    logic [63:0] mq[$];
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          m_started = 1'b0;
    bit          m_prev_stall = 1'b0;
    logic [63:0] m_prev_data = '0;

    axi_st_rd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .axist_valid (axist_valid),
        .axist_data  (axist_data),
        .axist_rdy   (axist_rdy),
        .fifo_full   (fifo_full),
        .fifo_wren   (fifo_wren),
        .fifo_wdata  (fifo_wdata),
        .beat_cnt    (beat_cnt),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs with the model, then advance the model by one cycle
    always @(negedge clk) begin
        bit exp_rdy;
        bit exp_wren;
        if (rst) begin
            mq.delete();
            m_cnt        = 0;
            m_err        = 1'b0;
            m_started    = 1'b0;
            m_prev_stall = 1'b0;
            check("rst_rdy", 64'(axist_rdy), 64'd0);
            check("rst_wren", 64'(fifo_wren), 64'd0);
            check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
            check("rst_proto_err", 64'(proto_err), 64'd0);
            check("rst_skid_count", 64'(dut.u_skid.r_count), 64'd0);
        end else begin
            exp_rdy  = m_started && (mq.size() < 2);
            exp_wren = (mq.size() != 0) && !fifo_full;
            check("rdy", 64'(axist_rdy), 64'(exp_rdy));
            check("wren", 64'(fifo_wren), 64'(exp_wren));
            check("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            check("proto_err", 64'(proto_err), 64'(m_err));
            check("push_when_full", 64'(axist_valid && axist_rdy && (dut.u_skid.r_count == 2'd2)), 64'd0);
            if (exp_wren) begin
                if (fifo_wren) begin
                    check("wdata", fifo_wdata, mq[0]);
                end
                void'(mq.pop_front());
                m_cnt++;
            end
            if (m_prev_stall && (!axist_valid || (axist_data != m_prev_data))) begin
                m_err = 1'b1;
            end
            if (axist_valid && exp_rdy) begin
                mq.push_back(axist_data);
            end
            m_prev_stall = axist_valid && !exp_rdy;
            m_prev_data  = axist_data;
            m_started    = 1'b1;
        end
    end

    task automatic do_reset();
        rst         = 1'b1;
        axist_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Compliant sender: holds a stalled beat unchanged, optional idle gaps.
    // mode: 0 full=0, 1 toggle, 2 full for 'hold' cycles, 3 random, 4 untouched
    task automatic send(input int n, input logic [63:0] base, input int mode, input int hold,
                        input bit gaps, output int cycles, output int held_acc);
        int i = 0;
        bit acc;
        cycles   = 0;
        held_acc = 0;
        while (i < n && cycles < 500) begin
            case (mode)
                0: fifo_full = 1'b0;
                1: fifo_full = ~fifo_full;
                2: begin
                    if (cycles == hold) held_acc = i;
                    fifo_full = (cycles < hold);
                end
                3: fifo_full = 1'($urandom % 2);
                default: ;
            endcase
            if (axist_valid || !gaps || (($urandom % 3) != 0)) begin
                axist_valid = 1'b1;
                axist_data  = base + 64'(i);
            end
            @(negedge clk);
            acc = axist_valid && axist_rdy;
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                i++;
                axist_valid = 1'b0;
            end
        end
        axist_valid = 1'b0;
        total++;
        if (i < n) begin
            bad++;
            $display("FAIL send_timeout: got %0d beats accepted expected %0d", i, n);
        end
    endtask

    task automatic drain();
        int k = 0;
        fifo_full = 1'b0;
        while (mq.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int held;

        // Reset release
        do_reset();

        // Back-to-back stream of 8 beats
        send(8, 64'h1, 0, 0, 1'b0, cyc, held);
        check("stream8_cycles", 64'(cyc), 64'd8);
        drain();
        check("stream8_beat_cnt", 64'(beat_cnt), 64'd8);
        check("stream8_proto_err", 64'(proto_err), 64'd0);

        // FIFO full at start: only two beats fit
        do_reset();
        fifo_full = 1'b1;
        send(4, 64'h1, 2, 6, 1'b0, cyc, held);
        check("full_held_accepts", 64'(held), 64'd2);
        drain();
        check("full_beat_cnt", 64'(beat_cnt), 64'd4);

        // FIFO full toggling every cycle
        do_reset();
        send(16, 64'h100, 1, 0, 1'b0, cyc, held);
        drain();
        check("toggle_beat_cnt", 64'(beat_cnt), 64'd16);

        // Random back-pressure and gaps
        do_reset();
        send(40, 64'h1000 + 64'($urandom % 256), 3, 0, 1'b1, cyc, held);
        drain();
        check("random_beat_cnt", 64'(beat_cnt), 64'd40);
        check("random_proto_err", 64'(proto_err), 64'd0);

        // Stalled beat whose data changes
        do_reset();
        fifo_full = 1'b1;
        send(2, 64'h10, 4, 0, 1'b0, cyc, held);
        axist_valid = 1'b1;
        axist_data  = 64'hA5;
        @(posedge clk); #1;
        axist_data  = 64'h5A;
        @(posedge clk); #1;
        axist_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("data_change_err", 64'(proto_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 64'(proto_err), 64'd1);

        // Stalled beat withdrawn
        do_reset();
        fifo_full = 1'b1;
        send(2, 64'h10, 4, 0, 1'b0, cyc, held);
        axist_valid = 1'b1;
        axist_data  = 64'hA5;
        @(posedge clk); #1;
        axist_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("withdraw_err", 64'(proto_err), 64'd1);

        // Reset with two beats buffered, then a fresh beat
        do_reset();
        fifo_full = 1'b1;
        send(2, 64'h20, 4, 0, 1'b0, cyc, held);
        check("prefill_count", 64'(dut.u_skid.r_count), 64'd2);
        do_reset();
        check("post_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("post_rst_proto_err", 64'(proto_err), 64'd0);
        send(1, 64'h77, 0, 0, 1'b0, cyc, held);
        drain();
        check("post_rst_single_beat", 64'(beat_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
